button_frame_rx: RTL
====================

BUTTON_FRAME_RX -- requirements
Module: button_frame_rx

Interface
REQ-001 SHALL provide parameter BITS, default 16, button word width; a multiple of 8, minimum 8.
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 2000000, number of system_clock cycles without a good frame before buttons revert to released.
REQ-003 SHALL have port system_clock  input  1  sole clock; every flop is clocked on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port spi_sck  input  1  SPI clock from the USB host MCU; mode 0, asynchronous to system_clock.
REQ-006 SHALL have port spi_cs_n  input  1  frame select, active low.
REQ-007 SHALL have port spi_mosi  input  1  serial data, MSB first.
REQ-008 SHALL have port console_latch  input  1  console latch pin, asynchronous; the same net drives the downstream parallel-to-serial shifter.
REQ-009 SHALL have port buttons  output  BITS  active-low button word for the downstream shifter parallel input.
REQ-010 SHALL have port frame_ok  output  1  one-cycle pulse per accepted frame.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse per rejected frame.
REQ-012 SHALL have port link_up  output  1  high while a good frame arrived within the last TIMEOUT_CYCLES.

Function
REQ-013 spi_sck, spi_cs_n, spi_mosi and console_latch SHALL each pass through a 2-flop synchronizer before use.
REQ-014 A bit SHALL be sampled on the system_clock after a synchronized sck rising edge, and only while synchronized cs_n is low.
REQ-015 Frame SHALL be: header byte 0xA5, then BITS data bits, then a checksum byte (see Configuration), all MSB first.
REQ-016 FSM states SHALL be IDLE, HEADER, DATA, CHECK, WAIT_END.
REQ-017 IDLE->HEADER on cs_n falling; HEADER->DATA after 8 bits equal to 0xA5; HEADER->WAIT_END with error on any other header value.
REQ-018 DATA->CHECK after BITS bits (CHECK skipped when checksum is disabled).
REQ-019 Any state other than IDLE SHALL return to IDLE on cs_n rising. Short frames (cs_n rising before the final bit) and long frames (extra sck edges after the final bit) SHALL raise frame_err and discard the received data.
REQ-020 A good frame SHALL be committed on the cycle after cs_n rising is detected: data loads into a pending register and frame_ok pulses.
REQ-021 The pending word SHALL copy to buttons only while synchronized console_latch is low. A commit during latch high SHALL be held and applied on the first cycle the latch is low, so buttons never change while the shifter is loading.
REQ-022 When a new commit overwrites a not-yet-applied pending word, the newest word SHALL win.
REQ-023 The timeout counter SHALL clear on frame_ok and saturate at TIMEOUT_CYCLES. On reaching it, link_up SHALL go low and buttons SHALL be set to all ones, also gated by the latch rule in REQ-021.
REQ-024 frame_ok and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-025 While reset_n is low: buttons all ones; frame_ok, frame_err and link_up 0; FSM in IDLE; counters 0; synchronizers reset to idle levels (cs_n and sck 1, mosi 0, latch 0).
REQ-026 Reset deasserted mid-frame SHALL resume in IDLE and ignore the remainder of the frame until the next cs_n falling edge.

Configuration
REQ-027 Macro FRAME_CHECKSUM_EN SHALL control the checksum feature.
REQ-028 With FRAME_CHECKSUM_EN defined: a trailing byte SHALL equal the XOR of all data bytes, and a mismatch SHALL raise frame_err with no commit.
REQ-029 Without FRAME_CHECKSUM_EN: no checksum byte; the frame is header plus data, and the CHECK state and its logic are absent.

Verification
REQ-030 Test 1 (checksum enabled, BITS=16, latch low): send A5 12 34 26 -> frame_ok pulse, buttons=0x1234, link_up=1.
REQ-031 Test 2: send A5 12 34 27 -> frame_err pulse, buttons unchanged.
REQ-032 Test 3: send 5A 12 34 26 -> frame_err; send A5 with cs_n rising after 12 bits -> frame_err; buttons unchanged in both cases.
REQ-033 Test 4: hold console_latch high, send frames with 0xAAAA then 0x5555 -> buttons steady; latch low -> buttons=0x5555 within 3 cycles.
REQ-034 Test 5: TIMEOUT_CYCLES=100, one good frame, then idle 100 cycles -> link_up=0, buttons=0xFFFF.
REQ-035 Test 6: assert reset_n mid-DATA, release, send A5 00 FF FF -> buttons=0x00FF.

Source files
------------

// File: rtl/button_frame_rx.sv
// SPI button-frame receiver: header 0xA5, BITS data bits, optional XOR checksum byte
// (enabled by FRAME_CHECKSUM_EN); the button word is only updated while console_latch is low.
module button_frame_rx #(
    parameter int unsigned BITS           = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic            system_clock,
    input  logic            reset_n,
    input  logic            spi_sck,
    input  logic            spi_cs_n,
    input  logic            spi_mosi,
    input  logic            console_latch,
    output logic [BITS-1:0] buttons,
    output logic            frame_ok,
    output logic            frame_err,
    output logic            link_up
);
    localparam int unsigned CW          = $clog2(BITS);
    localparam int unsigned TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  HEADER_BYTE = 8'hA5;
    localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT_CYCLES);

`ifdef FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, HEADER, DATA, CHECK, WAIT_END} state_t;
`else
    typedef enum logic [2:0] {IDLE, HEADER, DATA, WAIT_END} state_t;
`endif

    state_t          state_q, state_d;
    logic [1:0]      sck_sync_q, cs_sync_q, mosi_sync_q, latch_sync_q;
    logic            sck_prev_q, cs_prev_q;
    logic [1:0]      warm_q;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      sh_q;
    logic [BITS-1:0] data_q, pend_q, buttons_q;
    logic            good_q, pend_v_q, ok_q, err_q, link_q;
    logic [TW-1:0]   tmo_q;
    logic            sck_s, cs_s, mosi_s, latch_s;
    logic            sck_rise, cs_fall, cs_rise;
    logic            ok_d, err_d;
    logic [7:0]      byte_next;

    assign sck_s     = sck_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign latch_s   = latch_sync_q[1];
    assign sck_rise  = sck_s & ~sck_prev_q & ~cs_s;
    // A falling edge only counts once the synchronizer holds real samples, so a frame
    // already in progress at reset release is ignored until cs_n goes high again.
    assign cs_fall   = (warm_q == 2'd3) & cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign byte_next = {sh_q[6:0], mosi_s};

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q   <= 2'b11;
            cs_sync_q    <= 2'b11;
            mosi_sync_q  <= 2'b00;
            latch_sync_q <= 2'b00;
            sck_prev_q   <= 1'b1;
            cs_prev_q    <= 1'b1;
            warm_q       <= 2'd0;
        end else begin
            sck_sync_q   <= {sck_sync_q[0], spi_sck};
            cs_sync_q    <= {cs_sync_q[0], spi_cs_n};
            mosi_sync_q  <= {mosi_sync_q[0], spi_mosi};
            latch_sync_q <= {latch_sync_q[0], console_latch};
            sck_prev_q   <= sck_s;
            cs_prev_q    <= cs_s;
            if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
        end
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (cs_fall) state_d = HEADER;
            HEADER: begin
                if (cs_rise) state_d = IDLE;
                else if (sck_rise && cnt_q == CW'(7))
                    state_d = (byte_next == HEADER_BYTE) ? DATA : WAIT_END;
            end
            DATA: begin
                if (cs_rise) state_d = IDLE;
`ifdef FRAME_CHECKSUM_EN
                else if (sck_rise && cnt_q == CW'(BITS - 1)) state_d = CHECK;
            end
            CHECK: begin
                if (cs_rise) state_d = IDLE;
                else if (sck_rise && cnt_q == CW'(7)) state_d = WAIT_END;
`else
                else if (sck_rise && cnt_q == CW'(BITS - 1)) state_d = WAIT_END;
`endif
            end
            WAIT_END: if (cs_rise) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ok_d  = 1'b0;
        err_d = 1'b0;
        if (state_q != IDLE && cs_rise) begin
            if (state_q == WAIT_END && good_q) ok_d  = 1'b1;
            else                               err_d = 1'b1;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [7:0] xor_byte;
    always_comb begin
        xor_byte = '0;
        for (int unsigned i = 0; i < BITS / 8; i++) xor_byte = xor_byte ^ data_q[i*8 +: 8];
    end
`endif

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            sh_q   <= '0;
            data_q <= '0;
            good_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    good_q <= 1'b0;
                end
                HEADER: if (sck_rise) begin
                    sh_q  <= byte_next;
                    cnt_q <= (cnt_q == CW'(7)) ? '0 : cnt_q + CW'(1);
                end
                DATA: if (sck_rise) begin
                    data_q <= {data_q[BITS-2:0], mosi_s};
                    if (cnt_q == CW'(BITS - 1)) begin
                        cnt_q <= '0;
`ifndef FRAME_CHECKSUM_EN
                        good_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                CHECK: if (sck_rise) begin
                    sh_q  <= byte_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(7)) good_q <= (byte_next == xor_byte);
                end
`endif
                WAIT_END: if (sck_rise) good_q <= 1'b0;
                default: ;
            endcase
        end
    end

    // Commit and timeout both go through the pending word, so the latch gate covers both;
    // a commit is written after the apply so the newest word always wins.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
            link_q    <= 1'b0;
            tmo_q     <= '0;
            pend_q    <= '1;
            pend_v_q  <= 1'b0;
            buttons_q <= '1;
        end else begin
            ok_q  <= ok_d;
            err_q <= err_d;
            if (pend_v_q && !latch_s) begin
                buttons_q <= pend_q;
                pend_v_q  <= 1'b0;
            end
            if (ok_d) begin
                tmo_q    <= '0;
                link_q   <= 1'b1;
                pend_q   <= data_q;
                pend_v_q <= 1'b1;
            end else if (tmo_q != TMAX) begin
                tmo_q <= tmo_q + TW'(1);
                if (tmo_q == TMAX - TW'(1)) begin
                    link_q   <= 1'b0;
                    pend_q   <= '1;
                    pend_v_q <= 1'b1;
                end
            end
        end
    end

    assign buttons   = buttons_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign link_up   = link_q;
endmodule
